// File: rtl/memory_pkg.sv
// Shared definitions for the memory stage: opcode, access-size and FSM state
// enums, plus small helpers for lane selection, byte enables and store data.
package memory_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Byte offset actually used for an access: low address bits that would make
  // a half or word access misaligned are forced to zero.
  function automatic logic [1:0] eff_offset(mem_size_e size, logic [1:0] addr_lo);
    logic [1:0] off;
    case (size)
      SIZE_BYTE: off = addr_lo;
      SIZE_HALF: off = {addr_lo[1], 1'b0};
      default:   off = 2'b00;
    endcase
    return off;
  endfunction

  // True when the access does not sit on its natural boundary.
  function automatic logic is_misaligned(mem_size_e size, logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      default:   mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

  // Byte-enable mask for an access of the given size at the given lane.
  function automatic logic [3:0] byte_enable(mem_size_e size, logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = 4'b0011 << off;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane so the slave can pick any lane.
  function automatic logic [31:0] lane_replicate(mem_size_e size, logic [31:0] data);
    logic [31:0] rep;
    case (size)
      SIZE_BYTE: rep = {4{data[7:0]}};
      SIZE_HALF: rep = {2{data[15:0]}};
      default:   rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/memory_stage_load_aligner.sv
// Combinational load aligner: picks the addressed lane out of the read word
// and sign- or zero-extends it to 32 bits.
module load_aligner
  import memory_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic        sign_byte;
  logic        sign_half;

  // Shift the addressed lane down to bit 0, then extend according to size.
  always_comb begin
    shifted   = rdata_i >> {offset_i, 3'b000};
    sign_byte = ~unsigned_i & shifted[7];
    sign_half = ~unsigned_i & shifted[15];
    case (mem_size_e'(size_i))
      SIZE_BYTE: data_o = {{24{sign_byte}}, shifted[7:0]};
      SIZE_HALF: data_o = {{16{sign_half}}, shifted[15:0]};
      default:   data_o = shifted;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: passes ALU results through, or runs a single data-bus
// transaction (IDLE -> REQ -> WAIT) for loads and stores, with a WAIT
// timeout and bus-error reporting on fault_o.
// Optional build macro MEMORY_STAGE_MISALIGNED_TRAP_EN: misaligned half/word
// accesses raise fault_o instead of being silently aligned down.
module memory_stage
  import memory_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [1:0]  mem_op_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic [31:0] forward_memory_data_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_be_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic        dbus_err_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        fault_o
);

  localparam logic [7:0] LastWaitCount = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  offset_q, offset_d;
  mem_size_e   size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic [31:0] result_q, result_d;
  logic        fault_q, fault_d;

  mem_op_e     op_in;
  mem_size_e   size_in;
  logic [1:0]  offset_in;
  logic        is_mem;
  logic        trap;
  logic [31:0] load_data;

  load_aligner u_load_aligner (
    .rdata_i    (dbus_rdata_i),
    .offset_i   (offset_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (load_data)
  );

  // Decode the incoming instruction and decide whether it traps as misaligned.
  always_comb begin
    op_in     = mem_op_e'(mem_op_i);
    size_in   = mem_size_e'(mem_size_i);
    offset_in = eff_offset(size_in, alu_result_i[1:0]);
    is_mem    = (op_in == OP_LOAD) || (op_in == OP_STORE);
    trap      = 1'b0;
`ifdef MEMORY_STAGE_MISALIGNED_TRAP_EN
    trap      = is_misaligned(size_in, alu_result_i[1:0]);
`endif
  end

  // Next-state logic for the bus FSM, captured request and writeback result.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    offset_d   = offset_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    result_d   = 32'd0;
    fault_d    = 1'b0;
    stall_o    = 1'b0;

    case (state_q)
      IDLE: begin
        count_d = 8'd0;
        if (valid_i) begin
          if (!is_mem) begin
            valid_d  = 1'b1;
            result_d = alu_result_i;
          end else if (trap) begin
            fault_d = 1'b1;
          end else begin
            stall_o    = 1'b1;
            state_d    = REQ;
            addr_d     = alu_result_i[31:2];
            offset_d   = offset_in;
            size_d     = size_in;
            unsigned_d = mem_unsigned_i;
            we_d       = (op_in == OP_STORE);
            be_d       = byte_enable(size_in, offset_in);
            wdata_d    = lane_replicate(size_in, store_data_i);
          end
        end
      end

      REQ: begin
        stall_o = 1'b1;
        if (dbus_gnt_i) begin
          state_d = WAIT;
          count_d = 8'd0;
        end
      end

      WAIT: begin
        stall_o = 1'b1;
        if (dbus_rvalid_i) begin
          state_d = IDLE;
          count_d = 8'd0;
          if (dbus_err_i) begin
            fault_d = 1'b1;
          end else begin
            valid_d  = 1'b1;
            result_d = we_q ? 32'd0 : load_data;
          end
        end else if (count_q == LastWaitCount) begin
          state_d = IDLE;
          count_d = 8'd0;
          fault_d = 1'b1;
        end else begin
          count_d = count_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = 8'd0;
      end
    endcase
  end

  // Bus request is only presented while in REQ; all fields are quiet otherwise.
  always_comb begin
    dbus_req_o            = (state_q == REQ);
    dbus_we_o             = dbus_req_o & we_q;
    dbus_addr_o           = dbus_req_o ? {addr_q, 2'b00} : 32'd0;
    dbus_wdata_o          = dbus_req_o ? wdata_q : 32'd0;
    dbus_be_o             = dbus_req_o ? be_q : 4'd0;
    valid_o               = valid_q;
    result_o              = result_q;
    forward_memory_data_o = result_q;
    fault_o               = fault_q;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= 30'd0;
      offset_q   <= 2'd0;
      size_q     <= SIZE_BYTE;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      count_q    <= 8'd0;
      valid_q    <= 1'b0;
      result_q   <= 32'd0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      offset_q   <= offset_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      fault_q    <= fault_d;
    end
  end

endmodule
